// File: rtl/mips_mem_pkg.sv
// ============================================================================
// Module  : mips_mem_pkg
// Purpose : Shared types and constants for the pipeline memory responders.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mem_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   localparam logic [31:0] MEM_ERR_DATA = 32'hDEAD_BEEF;
   localparam int          WAIT_CNT_W   = 4;
endpackage

`default_nettype wire

// File: rtl/mem_wait_counter.sv
// ============================================================================
// Module  : mem_wait_counter
// Purpose : Loadable down-counter; done_o flags a zero count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_counter
   import mips_mem_pkg::*;
#(
   parameter int CNT_W = WAIT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] value_i,
   input  logic             dec_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module  : data_mem_responder
// Purpose : Single-word cs/ready memory target with programmable wait states.
//           Define MEM_RANGE_ERR_EN to add err_o and out-of-range protection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
   import mips_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  cs,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] data_i,
`ifdef MEM_RANGE_ERR_EN
   output logic                  err_o,
`endif
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  ready_o,
   output logic                  busy_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

   mem_state_t            state_q, state_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic                  we_q, we_d;
   logic                  oor_q, oor_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DEPTH_LOG2-1:0] addr_idx;
   logic                  addr_oor;
   logic                  cnt_load, cnt_dec, cnt_done;
   logic                  unused_addr;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   assign addr_idx = addr_i[DEPTH_LOG2+1:2];
`ifdef MEM_RANGE_ERR_EN
   assign addr_oor    = |addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2];
   assign unused_addr = &{1'b0, addr_i[1:0]};
`else
   assign addr_oor    = 1'b0;
   assign unused_addr = &{1'b0, addr_i[1:0], addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2]};
`endif

   mem_wait_counter #(
      .CNT_W (WAIT_CNT_W)
   ) u_wait_cnt (
      .clk     (clk),
      .rst     (rst),
      .load_i  (cnt_load),
      .value_i (WAIT_LOAD),
      .dec_i   (cnt_dec),
      .done_o  (cnt_done)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      we_d     = we_q;
      oor_d    = oor_q;
      wdata_d  = wdata_q;
      data_d   = data_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs) begin
               idx_d    = addr_idx;
               we_d     = we;
               oor_d    = addr_oor;
               wdata_d  = data_i;
               cnt_load = 1'b1;
               state_d  = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (!cs) begin
               state_d = IDLE;
            end else if (cnt_done) begin
               state_d = RESP;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Read data is captured on the edge that enters RESP, using the latched
      // (or, with zero wait states, just-accepted) request fields.
      if ((state_d == RESP) && (state_q != RESP) && !we_d) begin
         data_d = oor_d ? DATA_WIDTH'(MEM_ERR_DATA) : mem_q[idx_d];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         we_q    <= 1'b0;
         oor_q   <= 1'b0;
         wdata_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         oor_q   <= oor_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
      end
   end

   // Storage is never reset; writes commit on the edge leaving RESP.
   always_ff @(posedge clk) begin
      if ((state_q == RESP) && we_q && !oor_q) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign data_o  = data_q;
   assign ready_o = (state_q == RESP);
   assign busy_o  = (state_q != IDLE);
`ifdef MEM_RANGE_ERR_EN
   assign err_o   = (state_q == RESP) && oor_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module  : tb_data_mem_responder
// Purpose : Directed scoreboard bench for two responders (2 and 0 wait states).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

   localparam int WC [2] = '{2, 0};

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst [2];
   logic [31:0] addr [2];
   logic        cs [2];
   logic        we [2];
   logic [31:0] din [2];
   logic [31:0] data_o [2];
   logic        ready_o [2];
   logic        busy_o [2];
`ifdef MEM_RANGE_ERR_EN
   logic        err_o [2];
`endif

   int          n_assert = 0;
   int          n_fail   = 0;
   exp_t        sb [$];
   logic [31:0] model [int];
   logic [31:0] last_rd [2];
   longint      t_prev [2];

   always #5 clk = ~clk;

   data_mem_responder #(.WAIT_CYCLES(2)) u_dut_w2 (
      .clk (clk), .rst (rst[0]), .addr_i (addr[0]), .cs (cs[0]), .we (we[0]),
      .data_i (din[0]),
`ifdef MEM_RANGE_ERR_EN
      .err_o (err_o[0]),
`endif
      .data_o (data_o[0]), .ready_o (ready_o[0]), .busy_o (busy_o[0])
   );

   data_mem_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
      .clk (clk), .rst (rst[1]), .addr_i (addr[1]), .cs (cs[1]), .we (we[1]),
      .data_i (din[1]),
`ifdef MEM_RANGE_ERR_EN
      .err_o (err_o[1]),
`endif
      .data_o (data_o[1]), .ready_o (ready_o[1]), .busy_o (busy_o[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input int d, input string tag);
      chk({tag, " data_o"}, data_o[d], last_rd[d]);
      chk({tag, " ready_o"}, 32'(ready_o[d]), 32'd0);
      chk({tag, " busy_o"}, 32'(busy_o[d]), 32'd0);
`ifdef MEM_RANGE_ERR_EN
      chk({tag, " err_o"}, 32'(err_o[d]), 32'd0);
`endif
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with it idle.
   task automatic txn(input int d, input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input bit pchk, input string tag);
      exp_t e;
      int   n;
      int   key;
      logic oor;
      key = d * 4096 + int'(a[11:2]);
      oor = 1'b0;
`ifdef MEM_RANGE_ERR_EN
      oor = |a[31:12];
`endif
      e.err  = oor;
      e.data = w ? last_rd[d] : (oor ? 32'hDEAD_BEEF : model[key]);
      sb.push_back(e);
      addr[d] = a; we[d] = w; din[d] = wd; cs[d] = 1'b1;
      @(posedge clk);
      if (pchk) chk({tag, " period"}, 32'(($time - t_prev[d]) / 10), 32'(WC[d] + 2));
      t_prev[d] = $time;
      #1;
      addr[d] = $urandom; din[d] = $urandom; we[d] = ~w;
      @(negedge clk);
      n = 1;
      chk({tag, " busy_o"}, 32'(busy_o[d]), 32'd1);
      while (ready_o[d] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(WC[d] + 1));
      e = sb.pop_front();
      chk({tag, " data_o"}, data_o[d], e.data);
`ifdef MEM_RANGE_ERR_EN
      chk({tag, " err_o"}, 32'(err_o[d]), 32'(e.err));
`endif
      if (!w) last_rd[d] = e.data;
      else if (!oor) model[key] = wd;
      cs[d] = 1'b0;
      @(negedge clk);
      chk_idle(d, {tag, " after"});
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b0; cs[i] = 1'b0; we[i] = 1'b0;
         addr[i] = '0; din[i] = '0; last_rd[i] = '0; t_prev[i] = 0;
      end
      repeat (2) @(negedge clk);
      chk_idle(0, "reset w2");
      chk_idle(1, "reset w0");
      rst[0] = 1'b1; rst[1] = 1'b1;
      @(negedge clk);

      // Write then read with two wait states
      txn(0, 32'h40, 1'b1, 32'h1234_5678, 1'b0, "w2 wr 0x40");
      txn(0, 32'h40, 1'b0, 32'h0, 1'b1, "w2 rd 0x40");

      // Abort during WAIT leaves the word untouched
      txn(0, 32'h8, 1'b1, 32'h0, 1'b0, "w2 wr 0x8");
      cs[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; din[0] = 32'hAAAA_AAAA;
      @(posedge clk);
      @(negedge clk);
      chk("abort busy", 32'(busy_o[0]), 32'd1);
      cs[0] = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("abort ready", 32'(ready_o[0]), 32'd0);
      end
      chk("abort busy end", 32'(busy_o[0]), 32'd0);
      txn(0, 32'h8, 1'b0, 32'h0, 1'b0, "w2 rd 0x8");

      // Reset during WAIT of a write drops it
      txn(0, 32'h10, 1'b1, 32'h5555_0010, 1'b0, "w2 wr 0x10");
      txn(0, 32'h10, 1'b0, 32'h0, 1'b0, "w2 rd 0x10");
      cs[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; din[0] = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b0;
      #1;
      last_rd[0] = '0;
      chk_idle(0, "midop rst");
      cs[0] = 1'b0;
      @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      txn(0, 32'h10, 1'b0, 32'h0, 1'b0, "w2 rd 0x10 post");

      // Zero wait states, back-to-back
      txn(1, 32'h0, 1'b1, 32'd1, 1'b0, "w0 wr 0x0");
      txn(1, 32'h4, 1'b1, 32'd2, 1'b1, "w0 wr 0x4");
      txn(1, 32'h0, 1'b0, 32'h0, 1'b1, "w0 rd 0x0");
      txn(1, 32'h4, 1'b0, 32'h0, 1'b1, "w0 rd 0x4");

      // Reset mid-sim then idle
      rst[1] = 1'b0;
      #1;
      last_rd[1] = '0;
      chk_idle(1, "rst mid");
      @(negedge clk);
      rst[1] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk_idle(1, "idle");
      end

      // Address range handling
      txn(0, 32'h0, 1'b1, 32'h11, 1'b0, "w2 wr 0x0");
`ifdef MEM_RANGE_ERR_EN
      txn(0, 32'h1000, 1'b0, 32'h0, 1'b0, "oor rd");
      txn(0, 32'h1000, 1'b1, 32'h77, 1'b0, "oor wr");
`else
      txn(0, 32'h1000, 1'b1, 32'd5, 1'b0, "wrap wr");
`endif
      txn(0, 32'h0, 1'b0, 32'h0, 1'b0, "rd 0x0");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
